// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: FSM state encoding and IFMAP tag bit positions.
package conv_pkg;

  localparam int IFMAP_ELEMENT_WIDTH = 8;
  localparam int SOR_BIT = IFMAP_ELEMENT_WIDTH + 1;
  localparam int EOR_BIT = IFMAP_ELEMENT_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    SEND,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/feeder_addr_gen.sv
// Row/column counters and running read address for the ifmap feeder; derives sor/eor/last tags.
module feeder_addr_gen #(
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     advance,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROW_LEN_WIDTH-1:0] num_rows,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     sor,
  output logic                     eor,
  output logic                     last
);

  localparam logic [ROW_LEN_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = 1;

  logic [ROW_LEN_WIDTH-1:0] col;
  logic [ROW_LEN_WIDTH-1:0] row;
  logic [ROW_LEN_WIDTH-1:0] col_last;
  logic [ROW_LEN_WIDTH-1:0] row_last;

  // Terminal counts are latched at load so later changes on the inputs cannot disturb a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      col_last <= '0;
      row_last <= '0;
      addr     <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      col_last <= row_len - CNT_ONE;
      row_last <= num_rows - CNT_ONE;
      addr     <= base_addr;
    end else if (advance) begin
      addr <= addr + ADDR_ONE;
      if (col == col_last) begin
        col <= '0;
        row <= row + CNT_ONE;
      end else begin
        col <= col + CNT_ONE;
      end
    end
  end

  assign sor  = (col == '0);
  assign eor  = (col == col_last);
  assign last = eor && (row == row_last);

endmodule

// File: rtl/ifmap_stream_feeder.sv
// Streams ifmap elements from a sync-read SRAM to the IFMAP buffer as {sor, eor, data} words.
// Optional build macro FEEDER_STATS_EN adds the words_sent accepted-word counter port.
module ifmap_stream_feeder
  import conv_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_LEN_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROW_LEN_WIDTH-1:0] num_rows,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic                     mem_rd_en,
  input  logic [ELEMENT_WIDTH-1:0] mem_data,
  output logic [ELEMENT_WIDTH+1:0] IFMAP,
  output logic                     write_en_IFMAP,
  input  logic                     ifmap_full,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]              words_sent
`endif
);

  feeder_state_t state;
  logic          load;
  logic          accept;
  logic          sor;
  logic          eor;
  logic          last;
  logic          zero_len;

  assign zero_len       = (row_len == '0) || (num_rows == '0);
  assign load           = (state == IDLE) && start;
  // Combinational so a full consumer suppresses the strobe in the same cycle.
  assign write_en_IFMAP = (state == SEND) && !ifmap_full;
  assign accept         = write_en_IFMAP;

  feeder_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ROW_LEN_WIDTH(ROW_LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (accept),
    .base_addr(base_addr),
    .row_len  (row_len),
    .num_rows (num_rows),
    .addr     (mem_addr),
    .sor      (sor),
    .eor      (eor),
    .last     (last)
  );

  // NOTE: every register here uses <= so each branch sees pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      IFMAP     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (zero_len) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= REQ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        REQ: begin
          mem_rd_en <= 1'b0;
          state     <= CAP;
        end
        CAP: begin
          IFMAP <= {sor, eor, mem_data};
          state <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= REQ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || load) begin
      words_sent <= '0;
    end else if (accept && (words_sent != 16'hFFFF)) begin
      words_sent <= words_sent + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Scoreboard bench for ifmap_stream_feeder: expected words/addresses are queued, monitors pop on strobes.
module tb_ifmap_stream_feeder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [4:0] row_len;
  logic [4:0] num_rows;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_data;
  logic [9:0] IFMAP;
  logic       write_en_IFMAP;
  logic       ifmap_full;
  logic       busy;
  logic       done;
`ifdef FEEDER_STATS_EN
  logic [15:0] words_sent;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] word_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] mem[256];

  ifmap_stream_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .row_len       (row_len),
    .num_rows      (num_rows),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_data      (mem_data),
    .IFMAP         (IFMAP),
    .write_en_IFMAP(write_en_IFMAP),
    .ifmap_full    (ifmap_full),
    .busy          (busy),
    .done          (done)
`ifdef FEEDER_STATS_EN
    ,
    .words_sent    (words_sent)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read SRAM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] word, input logic [7:0] addr);
    word_q.push_back(word);
    addr_q.push_back(addr);
  endtask

  // Word monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (write_en_IFMAP) begin
      if (word_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_word: got %0h expected none", IFMAP);
      end else begin
        check("ifmap_word", 32'(IFMAP), 32'(word_q.pop_front()));
      end
    end
  end

  // Read monitor: every read strobe must target the oldest expected address.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_read: got addr %0h expected none", mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ifmap"}, 32'(IFMAP), 32'd0);
    check({tag, "_write_en"}, 32'(write_en_IFMAP), 32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Cycle c = c-th cycle after the start edge E0; inputs change at posedge+1, outputs sampled at negedge.
  task automatic run_xfer(input string name, input logic [7:0] base, input logic [4:0] rl,
                          input logic [4:0] nr, input int exp_done, input int stall_at,
                          input int stall_len, input logic [9:0] hold_word,
                          input int busy_start_at, input int rst_at);
    int  c;
    bit  seen;
    @(posedge clk); #1;
    base_addr = base;
    row_len   = rl;
    num_rows  = nr;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 8'h5A;
    row_len   = 5'd7;
    num_rows  = 5'd7;
    c    = 1;
    seen = 1'b0;
    while (!seen && c <= 200) begin
      ifmap_full = (c >= stall_at) && (c < stall_at + stall_len);
      start      = (c == busy_start_at);
      rst        = (c == rst_at);
      @(negedge clk);
      if (rst_at > 0 && c == rst_at + 1) begin
        check_all_zero({name, "_after_rst"});
        seen = 1'b1;
      end else begin
        if (ifmap_full) begin
          check({name, "_stall_we"}, 32'(write_en_IFMAP), 32'd0);
          check({name, "_stall_hold"}, 32'(IFMAP), 32'(hold_word));
        end
        if (done) begin
          seen = 1'b1;
          check({name, "_done_cycle"}, 32'(c), 32'(exp_done));
          check({name, "_busy_with_done"}, 32'(busy), 32'd1);
        end
      end
      if (!seen) begin
        @(posedge clk); #1;
        c++;
      end
    end
    @(posedge clk); #1;
    ifmap_full = 1'b0;
    start      = 1'b0;
    rst        = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done at %0d", name, c, exp_done);
    end else if (rst_at == 0) begin
      @(negedge clk);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    row_len    = '0;
    num_rows   = '0;
    ifmap_full = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hFF;
    mem[8'h01] = 8'hFC;
    mem[8'h02] = 8'hF8;
    mem[8'hFF] = 8'hA5;
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = 8'h11 + 8'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single row of three.
    push_exp(10'h2FF, 8'h00);
    push_exp(10'h0FC, 8'h01);
    push_exp(10'h1F8, 8'h02);
    run_xfer("single_row", 8'h00, 5'd3, 5'd1, 10, 0, 0, 10'h000, 0, 0);

    // Four full cycles during the second SEND delay done by four.
    push_exp(10'h2FF, 8'h00);
    push_exp(10'h0FC, 8'h01);
    push_exp(10'h1F8, 8'h02);
    run_xfer("backpressure", 8'h00, 5'd3, 5'd1, 14, 6, 4, 10'h0FC, 0, 0);

    // One-element rows wrap the address from FF to 00.
    push_exp(10'h3A5, 8'hFF);
    push_exp(10'h3FF, 8'h00);
    run_xfer("wrap", 8'hFF, 5'd1, 5'd2, 7, 0, 0, 10'h000, 0, 0);

    // Zero-length transfers read nothing and write nothing.
    run_xfer("zero_row_len", 8'h20, 5'd0, 5'd2, 1, 0, 0, 10'h000, 0, 0);
    run_xfer("zero_num_rows", 8'h20, 5'd3, 5'd0, 1, 0, 0, 10'h000, 0, 0);

    // Reset during SEND of element 2; element 3 is never read.
    push_exp(10'h2FF, 8'h00);
    push_exp(10'h0FC, 8'h01);
    run_xfer("mid_reset", 8'h00, 5'd3, 5'd1, 0, 0, 0, 10'h000, 0, 6);
    push_exp(10'h2FF, 8'h00);
    push_exp(10'h0FC, 8'h01);
    push_exp(10'h1F8, 8'h02);
    run_xfer("after_reset", 8'h00, 5'd3, 5'd1, 10, 0, 0, 10'h000, 0, 0);

    // 2x3 transfer with a start pulse while busy, which must be ignored.
    push_exp(10'h211, 8'h10);
    push_exp(10'h012, 8'h11);
    push_exp(10'h113, 8'h12);
    push_exp(10'h214, 8'h13);
    push_exp(10'h015, 8'h14);
    push_exp(10'h116, 8'h15);
    run_xfer("two_by_three", 8'h10, 5'd3, 5'd2, 19, 0, 0, 10'h000, 4, 0);
`ifdef FEEDER_STATS_EN
    check("words_sent", 32'(words_sent), 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("words_sent_hold", 32'(words_sent), 32'd6);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("word_q_drained", 32'(word_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifmap_stream_feeder.md
# ifmap_stream_feeder

Transmit side of the IFMAP write stream into `ConvolutionCalculator`. Reads raw ifmap elements row by row from a synchronous-read memory and emits each element as a tagged `ELEMENT_WIDTH+2`-bit word on `IFMAP` with a `write_en_IFMAP` strobe. Bit `ELEMENT_WIDTH+1` marks start-of-row and bit `ELEMENT_WIDTH` marks end-of-row. The block replaces hand-driven bench stimulus and sits between the ifmap SRAM and the calculator's IFMAP buffer.

## Interface
Parameters:
- `ELEMENT_WIDTH`, 8: data bits per ifmap element.
- `ADDR_WIDTH`, 8: memory address width.
- `ROW_LEN_WIDTH`, 5: width of the row-length and row-count fields.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `base_addr` in `ADDR_WIDTH`: address of the first element; sampled on the start edge.
- `row_len` in `ROW_LEN_WIDTH`: elements per row; sampled on the start edge.
- `num_rows` in `ROW_LEN_WIDTH`: number of rows; sampled on the start edge.
- `mem_addr` out `ADDR_WIDTH`: read address.
- `mem_rd_en` out 1: read strobe; data is returned on `mem_data` in the next cycle.
- `mem_data` in `ELEMENT_WIDTH`: read data.
- `IFMAP` out `ELEMENT_WIDTH+2`: tagged word {sor, eor, data}.
- `write_en_IFMAP` out 1: word valid; the consumer accepts it when `ifmap_full` is 0.
- `ifmap_full` in 1: consumer backpressure.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to REQ.
  - REQ: drive `mem_rd_en`=1 and `mem_addr`; go to CAP.
  - CAP: register {sor, eor, `mem_data`} into `IFMAP`; go to SEND.
  - SEND: on accept, go to REQ if more elements remain, otherwise go to DONE.
  - DONE: assert `done`; go to IDLE.
- Accept: `write_en_IFMAP`=1 and `ifmap_full`=0 in the same cycle.
- `write_en_IFMAP` = (state==SEND) && !`ifmap_full`. This is combinational from `ifmap_full`. While full, the block stays in SEND and holds `IFMAP` stable.
- Counters: `col` runs 0..`row_len`-1 and `row` runs 0..`num_rows`-1. On each accept, `col` increments; at the end of a row, `col` clears and `row` increments.
- Addressing: `mem_addr` = `base_addr` + `row`·`row_len` + `col`, computed as a running address incremented by 1 per accept. It wraps modulo 2^`ADDR_WIDTH`.
- Tag rules: sor = (`col`==0), eor = (`col`==`row_len`-1). When `row_len`==1 both tags are set.
- Zero-length transfer: if `row_len`==0 or `num_rows`==0 when `start` is sampled, the FSM goes IDLE→DONE. No memory reads and no writes occur, and `done` pulses one cycle later.
- `start` while busy: ignored. Parameter inputs are ignored after sampling.
- `rst` at any time, including mid-transfer: on the next edge the FSM goes to IDLE and counters clear. The in-flight element is dropped with no partial retry.

## Timing
- Reset values: `IFMAP`=0, `write_en_IFMAP`=0, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0:
  - `mem_rd_en`=1 in the cycle after E0.
  - `write_en_IFMAP`=1 from the third cycle after E0, provided `ifmap_full` is not asserted.
- Throughput: one word per 3 cycles with no backpressure. Each full-stalled cycle adds one cycle.
- `done` rises the cycle after the final accept, lasts one cycle, and `busy` falls together with it.
- Total cycles for N = `row_len`·`num_rows` elements with no stalls: 3N+1 from E0 to `done`.

## Configuration
- `FEEDER_STATS_EN` defined:
  - Adds output port `words_sent` [15:0], which counts accepted words.
  - Clears on `rst` and on `start` acceptance; saturates at 16'hFFFF.
  - Holds its value after `done`.
- `FEEDER_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum (IDLE, REQ, CAP, SEND, DONE).
  - Localparams `SOR_BIT`=`ELEMENT_WIDTH`+1 and `EOR_BIT`=`ELEMENT_WIDTH`, also used by `ConvolutionCalculator`.
- Sub-module `feeder_addr_gen`:
  - Holds the `row`/`col` counters and the running address.
  - Produces sor, eor and `last`; advances on an `advance` input.

## Test plan
- Single row: `row_len`=3, `num_rows`=1, mem[0..2]=FF,FC,F8. Required `IFMAP` words in order: 10'b1011111111, 10'b0011111100, 10'b0111111000. `done` pulses at cycle 10 after `start`.
- Backpressure: same setup with `ifmap_full`=1 for 4 cycles during the second SEND. `IFMAP` holds 10'b0011111100 with `write_en_IFMAP`=0, then resumes. `done` is delayed by exactly 4 cycles.
- Two rows with `row_len`=1, `base_addr`=8'hFF: reads are issued at FF then 00 (wrap). Both words carry tags 2'b11.
- Zero length: `row_len`=0 → no `mem_rd_en`, no writes, `done` one cycle after `start`.
- Reset in SEND of element 2 of 3: the next cycle shows all outputs 0 and state IDLE. A new `start` restarts from `base_addr` with sor=1.
- `FEEDER_STATS_EN`: a 2×3 transfer ends with `words_sent`=6, and `start` pulses issued while busy do not change it.
